// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and default timing.
// Imported by the host transmitter and the keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // 75 MHz: 100 us inhibit, 15 ms device clock watchdog
    localparam int PS2_INHIBIT_CYCLES = 7500;
    localparam int PS2_TIMEOUT_CYCLES = 1125000;
    localparam int PS2_FILTER_LEN     = 8;

    function automatic int ps2_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer then a FILTER_LEN-sample stability filter.
// Level changes appear 2+FILTER_LEN cycles after the pin; no backpressure.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic line_i,
    output logic level_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            // any sample matching the current level restarts the run
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-collector clock/data via output enables.
// Accepts on tx_valid && tx_ready (IDLE only); requests while busy are dropped, frame ends in tx_done or tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CW = $clog2(ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] WD_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ok_q, ok_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          clk_prev_q;

    logic clk_lvl, dat_lvl, clk_fall, wd_expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i    (clk),
        .reset_ni (reset),
        .line_i   (ps2_clk_in),
        .level_o  (clk_lvl)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i    (clk),
        .reset_ni (reset),
        .line_i   (ps2_dat_in),
        .level_o  (dat_lvl)
    );

    assign clk_fall   = clk_prev_q & ~clk_lvl;
    assign wd_expired = ~clk_fall & (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_d     = par_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    par_d    = ~^tx_data;
                    cnt_d    = INH_LOAD;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // device clock edges are meaningless while we hold the clock low
                if (cnt_q == '0) begin
                    dat_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            START: begin
                clk_oe_d  = 1'b0;
                bit_idx_d = 4'd0;
                cnt_d     = WD_LOAD;
                state_d   = SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
                if (clk_fall) begin
                    cnt_d = WD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end

                if (state_q == WAIT_IDLE && clk_lvl && dat_lvl) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else if (clk_fall) begin
                    if (state_q == SEND) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            dat_oe_d = ~data_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            dat_oe_d = ~par_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end
                    end else if (state_q == ACK) begin
                        ok_d    = ~dat_lvl;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            data_q     <= 8'd0;
            par_q      <= 1'b0;
            ok_q       <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ok_q       <= ok_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            clk_prev_q <= clk_lvl;
        end
    end

    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard monitor matches every done/error pulse against queued expectations.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TO   = 1000;
    localparam int FLT  = 8;
    localparam int HALF = 40;

    typedef struct {
        logic        done;
        logic        err;
        logic        chk;
        logic [10:0] bits;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk, dev_dat;
    logic [10:0] cap_bits;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // open-collector bus: either side can pull low
    assign ps2_clk_in = ps2_clk_oe ? 1'b0 : dev_clk;
    assign ps2_dat_in = ps2_dat_oe ? 1'b0 : dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (tx_done || tx_error)) begin
            check("pulse_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, tx_done, tx_error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_done", {31'd0, tx_done}, {31'd0, e.done});
                check("tx_error", {31'd0, tx_error}, {31'd0, e.err});
                if (e.chk) check("frame_bits", {21'd0, cap_bits}, {21'd0, e.bits});
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n;
        @(negedge clk);
        check("ready_before", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_falls", {31'd0, tx_ready}, 32'd0);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 4 * INH) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_dat_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("start_len", n, 1);
    endtask

    task automatic dev_frame(input bit ack, input bit glitch, input int abort_at);
        int n;
        logic [10:0] cap;
        n = 0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("dev_sees_release", {31'd0, n < 1000}, 32'd1);
        if (n >= 1000) return;
        repeat (30) @(negedge clk);
        cap[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (k == abort_at) begin
                repeat (20) @(negedge clk);
                check("abort_pre_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
                reset = 1'b0;
                #1;
                check("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                check("abort_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
                check("abort_busy", {31'd0, tx_busy}, 32'd0);
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                reset   = 1'b1;
                repeat (30) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (glitch && k == 4) begin
                repeat (5) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF / 2 - 8) @(negedge clk);
            end else begin
                repeat (HALF / 2) @(negedge clk);
            end
            cap[k] = ps2_dat_in;
            repeat (HALF / 2) @(negedge clk);
        end
        cap_bits = cap;
        if (ack) dev_dat = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("returns_idle", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        check("ready_after", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic frame(input logic [7:0] d, input logic [10:0] bits, input bit ack,
                         input bit glitch, input bit poke);
        exp_q.push_back('{done: ack, err: ~ack, chk: 1'b1, bits: bits});
        send(d);
        if (poke) begin
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            repeat (3) @(negedge clk);
            check("ready_low_busy", {31'd0, tx_ready}, 32'd0);
            tx_valid = 1'b0;
        end
        dev_frame(ack, glitch, 0);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        cap_bits = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_error", {31'd0, tx_error}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // {stop, parity, D7..D0, start}
        frame(PS2_CMD_SET_LEDS, 11'b1_1_1110_1101_0, 1'b1, 1'b0, 1'b0);
        frame(8'h01,            11'b1_0_0000_0001_0, 1'b1, 1'b0, 1'b1);
        frame(8'h00,            11'b1_1_0000_0000_0, 1'b1, 1'b0, 1'b0);
        frame(8'hF4,            11'b1_0_1111_0100_0, 1'b1, 1'b0, 1'b0);
        frame(8'hAA,            11'b1_1_1010_1010_0, 1'b0, 1'b0, 1'b0);

        // device never clocks
        exp_q.push_back('{done: 1'b0, err: 1'b1, chk: 1'b0, bits: 11'd0});
        send(8'hA5);
        n = 0;
        while (!tx_error && n < TO + 50) begin
            n++;
            @(negedge clk);
        end
        check("timeout_len", n, TO);
        check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("timeout_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        wait_idle();

        // reset at bit 4 (D3 of 0x30 is 0, so data is being pulled)
        send(8'h30);
        dev_frame(1'b1, 1'b0, 4);
        check("post_abort_ready", {31'd0, tx_ready}, 32'd1);
        frame(PS2_CMD_RESET,    11'b1_1_1111_1111_0, 1'b1, 1'b0, 1'b0);

        frame(PS2_CMD_SET_LEDS, 11'b1_1_1110_1101_0, 1'b1, 1'b1, 1'b0);

        repeat (20) @(negedge clk);
        check("expect_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the outbound counterpart of the keyboard receive driver.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs plus its argument, or 0xFF reset.
- Sits beside keyboard_press_driver in the clk (75 MHz) domain.
- Drives the open-collector PS2_CLK/PS2_DAT through output-enable signals. The top level ties each line low when its oe=1, else high-Z.
- Asserts tx_busy so the receiver can ignore the bus while a frame is in flight.

Parameters:
- INHIBIT_CYCLES, 7500: clock-low inhibit time (100 us at 75 MHz).
- TIMEOUT_CYCLES, 1125000: maximum gap between device clock falling edges, and wait for first edge (15 ms).
- FILTER_LEN, 8: consecutive identical synchronized samples needed to accept a line level change.

Ports:
- clk, in, 1: 75 MHz system clock.
- reset, in, 1: asynchronous, active-low reset.
- tx_valid, in, 1: request to send tx_data.
- tx_data, in, 8: command byte.
- tx_ready, out, 1: high only in IDLE; a transfer is accepted on tx_valid && tx_ready.
- tx_busy, out, 1: high in every state except IDLE.
- tx_done, out, 1: one-cycle pulse; device acknowledged.
- tx_error, out, 1: one-cycle pulse; timeout or missing ACK.
- ps2_clk_in, in, 1: raw PS2_CLK level.
- ps2_dat_in, in, 1: raw PS2_DAT level.
- ps2_clk_oe, out, 1: 1 = pull PS2_CLK low.
- ps2_dat_oe, out, 1: 1 = pull PS2_DAT low.

Behaviour:
- All outputs and state are registered. On reset assertion (async):
  - state=IDLE, tx_ready=1.
  - tx_busy, tx_done, tx_error, ps2_clk_oe and ps2_dat_oe all 0, so both lines are released immediately.
  - Filters preset to 1.
- Line conditioning:
  - Each input passes through a 2-FF synchronizer, then a FILTER_LEN stability filter.
  - A falling edge (fall) is a filtered clock change 1->0, valid for one cycle.
- Frame: 11 bits: start 0, D0..D7 LSB first, odd parity (bit = ~^tx_data), stop 1. The device then returns ACK=0.
- IDLE:
  - On accept, latch tx_data and compute parity.
  - Load the counter with INHIBIT_CYCLES-1 and set ps2_clk_oe=1.
  - Next state INHIBIT; tx_ready falls the cycle after accept.
- INHIBIT:
  - Count down. At 0, set ps2_dat_oe=1 (start bit) and hold for 1 cycle with clock still low.
  - Then set ps2_clk_oe=0, clear bit_idx, load the watchdog, and go to SEND.
- SEND:
  - On each fall, drive the next bit:
    - bit_idx 0..7: ps2_dat_oe = ~tx_data[bit_idx].
    - bit_idx 8: ps2_dat_oe = ~parity.
    - bit_idx 9: ps2_dat_oe = 0 (stop bit, released).
  - bit_idx increments on each fall; after bit_idx 9, go to ACK.
- ACK:
  - On the next fall, sample filtered data.
  - If 0, go to WAIT_IDLE with ok=1; otherwise go to WAIT_IDLE with ok=0.
- WAIT_IDLE:
  - Wait for filtered clock=1 and data=1.
  - Then pulse tx_done if ok, else pulse tx_error, and enter IDLE.
- Watchdog (SEND, ACK, WAIT_IDLE):
  - Reloads on every fall and counts down otherwise.
  - At 0: release both lines, pulse tx_error, go to IDLE.
- Boundaries:
  - tx_valid while busy is ignored, with no queueing.
  - tx_valid held high after done starts a new frame on the first IDLE cycle.
  - tx_done and tx_error are never both high.
  - A fall during INHIBIT is ignored (bus is held).
  - Reset mid-frame aborts with no pulse.
- Widths: inhibit/watchdog counter is $clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES)+1) bits; bit_idx is 4 bits.

Decomposition:
- Shared package ps2_pkg holds:
  - The state enum {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE}.
  - Command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_RSP_ACK=8'hFA.
  - Default timing constants.
- Sub-module ps2_line_filter: synchronizer plus stability filter, instantiated twice. keyboard_press_driver shall reuse it.

Test Plan:
- Send 0xED; the device model clocks at 12.5 kHz and ACKs. Require:
  - clk_oe low for exactly 7500 cycles.
  - Sampled bits 0,1,0,1,1,0,1,1,1,1 (start, 1,0,1,1,0,1,1,1, parity 1), stop 1.
  - One tx_done pulse, tx_error=0, tx_ready back to 1.
- Send 0x01 -> parity bit 0. Send 0x00 -> parity bit 1. Send 0xF4 -> parity 0. Each frame ends with tx_done.
- Device withholds ACK (data stays 1 on 11th fall) -> one tx_error pulse after lines go idle, no tx_done.
- Device never clocks after inhibit release -> tx_error exactly TIMEOUT_CYCLES after release, both oe=0.
- Assert reset at bit 4 -> both oe drop to 0 in the same cycle, no pulses; next 0xFF send completes normally.
- Glitch 3 cycles low on PS2_CLK during SEND -> no extra bit shifted; frame still matches.
